// File: rtl/vc_input_buffer_pkg.sv
// Shared NoC types and defaults for the router input-port buffer.
// Holds the flit payload type and the default buffer geometry constants.
package params_noc;

    localparam int FLIT_W = 16;
    typedef logic [FLIT_W-1:0] flit_Data_noVC;

    localparam int NUM_VC_DEF         = 2;
    localparam int VC_BUFFER_SIZE_DEF = 8;
    localparam int ON_THRESHOLD_DEF   = 2;
    localparam int OFF_THRESHOLD_DEF  = 6;

    // A single VC still needs a one-bit select field.
    function automatic int vc_sel_w(input int num_vc);
        return (num_vc > 1) ? $clog2(num_vc) : 1;
    endfunction

endpackage

// File: rtl/vc_input_buffer_if.sv
// Bundle of the link-side write/read request signals and per-VC status of the buffer.
// Requests are single-cycle strobes: a write or read takes effect at the clock edge where the
// strobe is high and the accept rule holds; the only backpressure is buf_On_Off/buf_full.
interface vc_input_buffer_if
    import params_noc::*;
#(
    parameter int NUM_VC      = NUM_VC_DEF,
    parameter int BUFFER_SIZE = VC_BUFFER_SIZE_DEF
);
    localparam int VC_W  = vc_sel_w(NUM_VC);
    localparam int CNT_W = $clog2(BUFFER_SIZE + 1);

    flit_Data_noVC             input_Data;
    logic                      write_i;
    logic [VC_W-1:0]           write_vc_i;
    logic                      read_i;
    logic [VC_W-1:0]           read_vc_i;
    flit_Data_noVC             output_Data;
    logic [NUM_VC-1:0]         buf_empty;
    logic [NUM_VC-1:0]         buf_full;
    logic [NUM_VC-1:0]         buf_On_Off;
    logic [NUM_VC*CNT_W-1:0]   num_Flits;
    logic                      overflow_o;
    logic                      underflow_o;

    modport master (
        output input_Data, write_i, write_vc_i, read_i, read_vc_i,
        input  output_Data, buf_empty, buf_full, buf_On_Off, num_Flits, overflow_o, underflow_o
    );

    modport slave (
        input  input_Data, write_i, write_vc_i, read_i, read_vc_i,
        output output_Data, buf_empty, buf_full, buf_On_Off, num_Flits, overflow_o, underflow_o
    );

endinterface

// File: rtl/vc_input_buffer_fifo_slice.sv
// One VC queue: circular storage with any depth >= 2, registered occupancy/status and
// hysteresis flow control. Accept decisions are made by the parent; this slice just obeys them.
module vc_fifo_slice
    import params_noc::*;
#(
    parameter int  BUFFER_SIZE   = VC_BUFFER_SIZE_DEF,
    parameter int  OFF_THRESHOLD = OFF_THRESHOLD_DEF,
    parameter int  ON_THRESHOLD  = ON_THRESHOLD_DEF,
    localparam int PTR_W         = $clog2(BUFFER_SIZE),
    localparam int CNT_W         = $clog2(BUFFER_SIZE + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_acc,
    input  logic             rd_acc,
    input  flit_Data_noVC    wr_data,
    output flit_Data_noVC    head,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full,
    output logic             on_off
);

    flit_Data_noVC    mem [BUFFER_SIZE];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_nxt;
    logic             on_off_nxt;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUFFER_SIZE - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        count_nxt  = count + CNT_W'(wr_acc) - CNT_W'(rd_acc);
        on_off_nxt = on_off;
        if (count_nxt >= CNT_W'(OFF_THRESHOLD))
            on_off_nxt = 1'b0;
        else if (count_nxt <= CNT_W'(ON_THRESHOLD))
            on_off_nxt = 1'b1;
    end

    // Storage is deliberately left out of reset; only pointers and status are cleared.
    always_ff @(posedge clk) begin
        if (wr_acc)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
            on_off <= 1'b1;
        end else begin
            if (wr_acc) wr_ptr <= ptr_inc(wr_ptr);
            if (rd_acc) rd_ptr <= ptr_inc(rd_ptr);
            count  <= count_nxt;
            empty  <= (count_nxt == '0);
            full   <= (count_nxt == CNT_W'(BUFFER_SIZE));
            on_off <= on_off_nxt;
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/vc_input_buffer.sv
// Router input-port buffer: NUM_VC independent queues behind one write port and one read port,
// with per-VC status, hysteresis flow control and sticky overflow/underflow flags.
module vc_input_buffer
    import params_noc::*;
#(
    parameter int NUM_VC        = NUM_VC_DEF,
    parameter int BUFFER_SIZE   = VC_BUFFER_SIZE_DEF,
    parameter int OFF_THRESHOLD = OFF_THRESHOLD_DEF,
    parameter int ON_THRESHOLD  = ON_THRESHOLD_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    vc_input_buffer_if.slave   bus
);

    localparam int VC_W  = vc_sel_w(NUM_VC);
    localparam int CNT_W = $clog2(BUFFER_SIZE + 1);

    logic [NUM_VC-1:0] wr_acc;
    logic [NUM_VC-1:0] rd_acc;
    logic [NUM_VC-1:0] empty_v;
    logic [NUM_VC-1:0] full_v;
    logic [NUM_VC-1:0] on_off_v;
    logic [CNT_W-1:0]  cnt_v  [NUM_VC];
    flit_Data_noVC     head_v [NUM_VC];
    logic              wr_in_range;
    logic              rd_in_range;
    logic              ovf_evt;
    logic              unf_evt;
    logic              overflow_q;
    logic              underflow_q;

    assign wr_in_range = (32'(bus.write_vc_i) < NUM_VC);
    assign rd_in_range = (32'(bus.read_vc_i) < NUM_VC);

    // A full VC still takes a write when the same VC is popped in that cycle.
    always_comb begin
        wr_acc  = '0;
        rd_acc  = '0;
        ovf_evt = 1'b0;
        unf_evt = 1'b0;
        for (int v = 0; v < NUM_VC; v++) begin
            if (bus.read_i && rd_in_range && bus.read_vc_i == VC_W'(v)) begin
                if (empty_v[v]) unf_evt   = 1'b1;
                else            rd_acc[v] = 1'b1;
            end
            if (bus.write_i && wr_in_range && bus.write_vc_i == VC_W'(v)) begin
                if (!full_v[v] || (bus.read_i && bus.read_vc_i == VC_W'(v))) wr_acc[v] = 1'b1;
                else                                                         ovf_evt   = 1'b1;
            end
        end
    end

    for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
        vc_fifo_slice #(
            .BUFFER_SIZE   (BUFFER_SIZE),
            .OFF_THRESHOLD (OFF_THRESHOLD),
            .ON_THRESHOLD  (ON_THRESHOLD)
        ) u_slice (
            .clk     (clk),
            .rst_n   (rst_n),
            .wr_acc  (wr_acc[v]),
            .rd_acc  (rd_acc[v]),
            .wr_data (bus.input_Data),
            .head    (head_v[v]),
            .count   (cnt_v[v]),
            .empty   (empty_v[v]),
            .full    (full_v[v]),
            .on_off  (on_off_v[v])
        );
        assign bus.num_Flits[v*CNT_W +: CNT_W] = cnt_v[v];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_q  | ovf_evt;
            underflow_q <= underflow_q | unf_evt;
        end
    end

    assign bus.output_Data = rd_in_range ? head_v[bus.read_vc_i] : '0;
    assign bus.buf_empty   = empty_v;
    assign bus.buf_full    = full_v;
    assign bus.buf_On_Off  = on_off_v;
    assign bus.overflow_o  = overflow_q;
    assign bus.underflow_o = underflow_q;

endmodule

// File: tb/tb_vc_input_buffer.sv
// Directed bench for vc_input_buffer: an 8-deep instance for fill/drain/full-bypass/reset and
// a 5-deep instance for pointer wrap with interleaved traffic against expected queues.
module tb_vc_input_buffer;
    import params_noc::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    vc_input_buffer_if #(.NUM_VC(2), .BUFFER_SIZE(8)) ifa ();
    vc_input_buffer_if #(.NUM_VC(2), .BUFFER_SIZE(5)) ifb ();

    vc_input_buffer #(.NUM_VC(2), .BUFFER_SIZE(8), .OFF_THRESHOLD(6), .ON_THRESHOLD(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa.slave)
    );
    vc_input_buffer #(.NUM_VC(2), .BUFFER_SIZE(5), .OFF_THRESHOLD(4), .ON_THRESHOLD(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb.slave)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] exp_q0[$];
    logic [15:0] exp_q1[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        ifa.input_Data = '0; ifa.write_i = 1'b0; ifa.write_vc_i = '0; ifa.read_i = 1'b0; ifa.read_vc_i = '0;
        ifb.input_Data = '0; ifb.write_i = 1'b0; ifb.write_vc_i = '0; ifb.read_i = 1'b0; ifb.read_vc_i = '0;
    endtask

    task automatic chk_reset_a(input string tag);
        chk({tag, "_empty"},  32'(ifa.buf_empty),   32'h3);
        chk({tag, "_full"},   32'(ifa.buf_full),    32'h0);
        chk({tag, "_onoff"},  32'(ifa.buf_On_Off),  32'h3);
        chk({tag, "_cnt"},    32'(ifa.num_Flits),   32'h0);
        chk({tag, "_ovf"},    32'(ifa.overflow_o),  32'h0);
        chk({tag, "_unf"},    32'(ifa.underflow_o), 32'h0);
    endtask

    initial begin
        int  w, r, n0, n1;
        bit  rd, wacc, racc, m_unf;

        idle_all();

        // 1: reset
        rst_n = 1'b0;
        step();
        step();
        chk_reset_a("rst");
        chk("rst_b_empty", 32'(ifb.buf_empty), 32'h3);
        rst_n = 1'b1;

        // 2: fill VC0 with 1..8, then one dropped write
        ifa.write_i = 1'b1; ifa.write_vc_i = 1'b0; ifa.read_vc_i = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            ifa.input_Data = 16'(i);
            step();
            chk("fill_cnt0",  32'(ifa.num_Flits[3:0]), 32'(i));
            chk("fill_onoff0", 32'(ifa.buf_On_Off[0]), (i >= 6) ? 32'h0 : 32'h1);
            chk("fill_full0", 32'(ifa.buf_full[0]),    (i == 8) ? 32'h1 : 32'h0);
        end
        chk("fill_head0", 32'(ifa.output_Data), 32'h1);
        chk("fill_cnt1",  32'(ifa.num_Flits[7:4]), 32'h0);
        chk("fill_empty1", 32'(ifa.buf_empty[1]), 32'h1);
        ifa.input_Data = 16'h00ff;
        step();
        chk("ovf_flag", 32'(ifa.overflow_o), 32'h1);
        chk("ovf_cnt0", 32'(ifa.num_Flits[3:0]), 32'h8);
        chk("ovf_head0", 32'(ifa.output_Data), 32'h1);
        ifa.write_i = 1'b0;

        // 3: drain VC0 in order, then one read on empty
        ifa.read_i = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            chk("drain_head", 32'(ifa.output_Data), 32'(i));
            step();
            chk("drain_cnt0",   32'(ifa.num_Flits[3:0]), 32'(8 - i));
            chk("drain_onoff0", 32'(ifa.buf_On_Off[0]), (8 - i <= 2) ? 32'h1 : 32'h0);
            chk("drain_empty0", 32'(ifa.buf_empty[0]),  (i == 8) ? 32'h1 : 32'h0);
            chk("drain_unf",    32'(ifa.underflow_o),   32'h0);
        end
        step();
        chk("unf_flag", 32'(ifa.underflow_o), 32'h1);
        chk("unf_cnt0", 32'(ifa.num_Flits[3:0]), 32'h0);
        ifa.read_i = 1'b0;

        rst_n = 1'b0;
        step();
        chk("rst2_ovf", 32'(ifa.overflow_o), 32'h0);
        chk("rst2_unf", 32'(ifa.underflow_o), 32'h0);
        rst_n = 1'b1;

        // 4: full VC0 with same-cycle write 9 and read
        ifa.write_i = 1'b1; ifa.write_vc_i = 1'b0; ifa.read_vc_i = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            ifa.input_Data = 16'(i);
            step();
        end
        chk("byp_pre_full", 32'(ifa.buf_full[0]), 32'h1);
        ifa.input_Data = 16'h0009;
        ifa.read_i = 1'b1;
        chk("byp_pre_head", 32'(ifa.output_Data), 32'h1);
        step();
        chk("byp_cnt0",  32'(ifa.num_Flits[3:0]), 32'h8);
        chk("byp_full0", 32'(ifa.buf_full[0]),    32'h1);
        chk("byp_ovf",   32'(ifa.overflow_o),     32'h0);
        ifa.write_i = 1'b0;
        for (int i = 2; i <= 9; i++) begin
            chk("byp_head", 32'(ifa.output_Data), 32'(i));
            step();
        end
        ifa.read_i = 1'b0;
        chk("byp_empty0", 32'(ifa.buf_empty[0]), 32'h1);
        chk("byp_unf",    32'(ifa.underflow_o),  32'h0);

        // 5: 5-deep instance, alternating VC writes with reads, 20 cycles
        m_unf = 1'b0;
        for (int c = 0; c < 20; c++) begin
            w  = c % 2;
            rd = (c >= 2);
            r  = (c / 2) % 2;
            ifb.write_i    = 1'b1;
            ifb.write_vc_i = 1'(w);
            ifb.input_Data = 16'(16'h10 + c);
            ifb.read_i     = rd;
            ifb.read_vc_i  = 1'(r);
            n0 = exp_q0.size();
            n1 = exp_q1.size();
            racc = rd && ((r == 0) ? (n0 != 0) : (n1 != 0));
            if (rd && !racc) m_unf = 1'b1;
            wacc = !(((w == 0) ? n0 : n1) == 5) || (rd && r == w);
            if (racc)
                chk("wrap_head", 32'(ifb.output_Data), (r == 0) ? 32'(exp_q0[0]) : 32'(exp_q1[0]));
            step();
            if (racc) begin
                if (r == 0) void'(exp_q0.pop_front());
                else        void'(exp_q1.pop_front());
            end
            if (wacc) begin
                if (w == 0) exp_q0.push_back(16'(16'h10 + c));
                else        exp_q1.push_back(16'(16'h10 + c));
            end
            chk("wrap_cnt0", 32'(ifb.num_Flits[2:0]), 32'(exp_q0.size()));
            chk("wrap_cnt1", 32'(ifb.num_Flits[5:3]), 32'(exp_q1.size()));
            chk("wrap_unf",  32'(ifb.underflow_o),    32'(m_unf));
            chk("wrap_ovf",  32'(ifb.overflow_o),     32'h0);
        end
        idle_all();
        ifb.read_vc_i = 1'b1;
        #1;
        if (exp_q1.size() != 0)
            chk("wrap_tail_head1", 32'(ifb.output_Data), 32'(exp_q1[0]));

        // 6: asynchronous reset in the middle of filling VC1
        ifa.write_i = 1'b1; ifa.write_vc_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ifa.input_Data = 16'(16'ha0 + i);
            step();
        end
        ifa.write_i = 1'b0;
        chk("mid_cnt1",   32'(ifa.num_Flits[7:4]), 32'h3);
        chk("mid_empty1", 32'(ifa.buf_empty[1]),   32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_a("async_rst");
        chk("async_rst_b_cnt", 32'(ifb.num_Flits), 32'h0);
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_cnt", 32'(ifa.num_Flits), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
